// File: rtl/timer_cpu_pkg.sv
// ============================================================================
// Module      : timer_cpu_pkg
// Description : Shared constants for the timer/compare bus peripheral:
//               register indices, CTRL/STATUS bit positions and the
//               peripheral's entry in the CPU address map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_cpu_pkg;

  // Peripheral identifiers on the CPU data bus; the timer's own entry.
  typedef enum logic [1:0] {
    PERIPH_IO    = 2'd0,
    PERIPH_UART  = 2'd1,
    PERIPH_TIMER = 2'd2
  } timer_e;

  // Byte address range claimed by the timer in the CPU address map.
  localparam logic [15:0] TIMER_ADDR_LO = 16'h0000;
  localparam logic [15:0] TIMER_ADDR_HI = 16'h001F;

  // Register indices (byte address = base + index * stride).
  localparam logic [2:0] CTRL_IDX     = 3'd0;
  localparam logic [2:0] PRESCALE_IDX = 3'd1;
  localparam logic [2:0] COMPARE_IDX  = 3'd2;
  localparam logic [2:0] COUNT_IDX    = 3'd3;
  localparam logic [2:0] STATUS_IDX   = 3'd4;
  localparam logic [2:0] CAPTURE_IDX  = 3'd5;

  // Number of decoded indices with and without the capture register.
  localparam int unsigned NUM_REGS_BASE = 5;
  localparam int unsigned NUM_REGS_CAP  = 6;

  // CTRL bit positions.
  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_AR_BIT  = 1;
  localparam int unsigned CTRL_IRQ_BIT = 2;

  // STATUS bit positions.
  localparam int unsigned STATUS_MATCH_BIT = 0;
  localparam int unsigned STATUS_CAP_BIT   = 1;

  // Assemble the CTRL read value; undefined bits read as zero.
  function automatic logic [31:0] ctrl_word(input logic en, input logic ar,
                                            input logic irq_en);
    logic [31:0] w;
    w               = '0;
    w[CTRL_EN_BIT]  = en;
    w[CTRL_AR_BIT]  = ar;
    w[CTRL_IRQ_BIT] = irq_en;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_cpu_prescaler.sv
// ============================================================================
// Module      : timer_prescaler
// Description : Divides the clock into single-cycle ticks. The internal
//               counter runs 0..prescale_i while enabled and pulses tick_o
//               on the terminal value; clr_i restarts it from zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler #(
  parameter int unsigned PrescaleWidth = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic [PrescaleWidth-1:0] prescale_i,
  output logic                     tick_o
);

  logic [PrescaleWidth-1:0] pcnt_q, pcnt_d;

  assign tick_o = en_i && (pcnt_q == prescale_i);

  // Next count: restart on disable, explicit clear or terminal value.
  always_comb begin
    pcnt_d = pcnt_q + PrescaleWidth'(1);
    if (!en_i || clr_i || tick_o) begin
      pcnt_d = '0;
    end
  end

  // Prescaler counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_cpu.sv
// ============================================================================
// Module      : timer_cpu
// Description : Memory-mapped timer/compare peripheral on the CPU data bus.
//               CTRL/PRESCALE/COMPARE/COUNT/STATUS registers, registered
//               read data, registered level interrupt.
//               Optional macro TIMER_CPU_CAPTURE_EN adds capture_i, a
//               CAPTURE register (index 5) and STATUS[1] CAP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_cpu
  import timer_cpu_pkg::*;
#(
  parameter int unsigned BaseAddress     = 0,
  parameter int unsigned address_width   = 16,
  parameter int unsigned data_width      = 32,
  parameter int unsigned Address_Wording = 4,
  parameter int unsigned PrescaleWidth   = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
`ifdef TIMER_CPU_CAPTURE_EN
  input  logic                     capture_i,
`endif
  output logic [data_width-1:0]    data_o,
  output logic                     irq_o
);

`ifdef TIMER_CPU_CAPTURE_EN
  localparam int unsigned NUM_REGS = NUM_REGS_CAP;
`else
  localparam int unsigned NUM_REGS = NUM_REGS_BASE;
`endif

  localparam logic [address_width-1:0] ADDR_BASE   = address_width'(BaseAddress);
  localparam logic [address_width-1:0] ADDR_STRIDE = address_width'(Address_Wording);
  localparam logic [address_width-1:0] ADDR_NREGS  = address_width'(NUM_REGS);

  // Address decode: aligned offsets above the base that land on a register.
  logic [address_width-1:0] offset, quot, rem;
  logic                     hit;
  logic [2:0]               idx;

  assign offset = address_i - ADDR_BASE;
  assign quot   = offset / ADDR_STRIDE;
  assign rem    = offset % ADDR_STRIDE;
  assign hit    = (address_i >= ADDR_BASE) && (rem == '0) && (quot < ADDR_NREGS);
  assign idx    = quot[2:0];

  logic [31:0] wdata;
  logic        wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;

  assign wdata       = 32'(data_i);
  assign wr_ctrl     = rd_wr_i && hit && (idx == CTRL_IDX);
  assign wr_prescale = rd_wr_i && hit && (idx == PRESCALE_IDX);
  assign wr_compare  = rd_wr_i && hit && (idx == COMPARE_IDX);
  assign wr_count    = rd_wr_i && hit && (idx == COUNT_IDX);
  assign wr_status   = rd_wr_i && hit && (idx == STATUS_IDX);

  // Architectural state.
  logic                     en_q, en_d;
  logic                     ar_q, ar_d;
  logic                     irq_en_q, irq_en_d;
  logic [PrescaleWidth-1:0] prescale_q, prescale_d;
  logic [31:0]              compare_q, compare_d;
  logic [31:0]              count_q, count_d;
  logic                     match_q, match_d;
  logic [data_width-1:0]    data_q, data_d;
  logic                     irq_q, irq_d;
  logic                     tick;
  logic                     match_hit;
  logic                     cap_flag;
  logic [31:0]              rdata;

  // Any write that restarts the count also restarts the prescale period.
  timer_prescaler #(
    .PrescaleWidth(PrescaleWidth)
  ) u_prescaler (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .en_i       (en_q),
    .clr_i      (wr_prescale | wr_count),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

`ifdef TIMER_CPU_CAPTURE_EN
  logic [2:0]  cap_sync_q;
  logic [31:0] capture_q, capture_d;
  logic        cap_q, cap_d;
  logic        cap_edge;

  assign cap_edge = cap_sync_q[1] & ~cap_sync_q[2];
  assign cap_flag = cap_q;

  // Two-flop synchroniser plus one delay stage for rising-edge detection.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cap_sync_q <= '0;
    end else begin
      cap_sync_q <= {cap_sync_q[1:0], capture_i};
    end
  end

  // Capture latches the pre-write COUNT; a new edge beats a W1C.
  always_comb begin
    capture_d = capture_q;
    cap_d     = cap_q;
    if (wr_status && wdata[STATUS_CAP_BIT]) cap_d = 1'b0;
    if (cap_edge) begin
      capture_d = count_q;
      cap_d     = 1'b1;
    end
  end

  // Capture register and CAP flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      capture_q <= '0;
      cap_q     <= 1'b0;
    end else begin
      capture_q <= capture_d;
      cap_q     <= cap_d;
    end
  end
`else
  assign cap_flag = 1'b0;
`endif

  // Read mux over current register values; misses return zero.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (idx)
        CTRL_IDX:     rdata = ctrl_word(en_q, ar_q, irq_en_q);
        PRESCALE_IDX: rdata = 32'(prescale_q);
        COMPARE_IDX:  rdata = compare_q;
        COUNT_IDX:    rdata = count_q;
        STATUS_IDX:   rdata = {30'd0, cap_flag, match_q};
`ifdef TIMER_CPU_CAPTURE_EN
        CAPTURE_IDX:  rdata = capture_q;
`endif
        default:      rdata = '0;
      endcase
    end
  end

  // Next-state: tick handling first, then bus writes so writes win.
  always_comb begin
    en_d       = en_q;
    ar_d       = ar_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    count_d    = count_q;
    match_d    = match_q;
    match_hit  = 1'b0;

    // A COUNT write in a tick cycle suppresses both increment and match.
    if (tick && !wr_count) begin
      if (count_q == compare_q) begin
        match_hit = 1'b1;
        if (ar_q) count_d = '0;
        else      en_d    = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_status && wdata[STATUS_MATCH_BIT]) match_d = 1'b0;
    if (match_hit) match_d = 1'b1;

    if (wr_ctrl) begin
      en_d     = wdata[CTRL_EN_BIT];
      ar_d     = wdata[CTRL_AR_BIT];
      irq_en_d = wdata[CTRL_IRQ_BIT];
    end
    if (wr_prescale) prescale_d = wdata[PrescaleWidth-1:0];
    if (wr_compare)  compare_d  = wdata;
    if (wr_count)    count_d    = wdata;

    data_d = (hit && !rd_wr_i) ? data_width'(rdata) : '0;
    irq_d  = (match_q | cap_flag) & irq_en_q;
  end

  // Register bank, read data and interrupt output.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_q       <= 1'b0;
      ar_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= '0;
      compare_q  <= '0;
      count_q    <= '0;
      match_q    <= 1'b0;
      data_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      ar_q       <= ar_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      count_q    <= count_d;
      match_q    <= match_d;
      data_q     <= data_d;
      irq_q      <= irq_d;
    end
  end

  assign data_o = data_q;
  assign irq_o  = irq_q;

endmodule

`default_nettype wire
